dram_rd_fetch: RTL and testbench

DRAM_RD_FETCH -- requirements
Module: dram_rd_fetch

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/dram_rd_fetch.sv | 186 ++++++++++++++++++
 tb/tb_dram_rd_fetch.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the DRAM read-fetch engine.
// Holds the fetch FSM state encoding and FIFO pointer-width helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int FIFO_DEPTH_DEF = 4;

    // Pointer width for a power-of-two FIFO; at least 1 bit.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH_DEF);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous return-data FIFO for dram_rd_fetch (power-of-two DEPTH).
// Ports: clk, srst, push/din, pop/dout, full, empty, count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int PW    = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when a pop frees a slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dram_rd_fetch.sv
// DRAM read-fetch engine: issues req_len word reads from req_base and
// streams the returned words to a valid/ready consumer via a FIFO.
// Ports: req_* (request), dram_* (read strobe/addr, 1-cycle return),
// out_* (stream, out_last on final word), busy, done (1-cycle pulse).
// Macro DRAM_RD_FETCH_STRIDE_EN adds ROW_STRIDE and req_cols for
// 2-D (row/column) addressing; default build is linear addressing.
module dram_rd_fetch
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4
`ifdef DRAM_RD_FETCH_STRIDE_EN
    ,
    parameter int ROW_STRIDE = 32
`endif
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_base,
    input  logic [LEN_WIDTH-1:0]  req_len,
`ifdef DRAM_RD_FETCH_STRIDE_EN
    input  logic [LEN_WIDTH-1:0]  req_cols,
`endif
    output logic                  dram_en_rd,
    output logic [ADDR_WIDTH-1:0] dram_addr_rd,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] dram_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = fifo_ptr_w(FIFO_DEPTH);
    localparam logic [PW+1:0] DEPTH_C = (PW+2)'(FIFO_DEPTH);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issue_cnt_q;
    logic [LEN_WIDTH-1:0]  pop_cnt_q;
    logic                  inflight_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  accept;
    logic                  rd_en;
    logic                  last_issue;
    logic                  last_word;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PW:0]           fifo_count;
    logic [PW+1:0]         occupancy;

    // Occupancy counts the read whose data lands this cycle, so a new
    // read is only issued when its return is guaranteed a slot.
    assign occupancy  = {1'b0, fifo_count} + (PW+2)'(inflight_q);
    assign accept     = req_valid && req_ready;
    assign last_issue = rd_en && (issue_cnt_q + LEN_WIDTH'(1) == len_q);
    assign last_word  = (pop_cnt_q + LEN_WIDTH'(1) == len_q);
    // Only returns of reads issued since reset are accepted, which
    // drops a stale beat arriving just after a mid-request reset.
    assign push       = dram_valid && inflight_q;
    assign pop        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (srst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && req_len != '0) state_d = ISSUE;
            ISSUE:   if (last_issue) state_d = DRAIN;
            DRAIN:   if (pop && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state_q == IDLE) && !srst;
        busy         = (state_q != IDLE);
        rd_en        = (state_q == ISSUE) && (occupancy < DEPTH_C);
        dram_en_rd   = rd_en;
        dram_addr_rd = rd_en ? rd_addr : '0;
        out_valid    = !fifo_empty;
        out_last     = out_valid && busy && last_word;
        done         = done_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            len_q       <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            done_q     <= (accept && req_len == '0) || (pop && out_last);
            if (accept) begin
                len_q       <= req_len;
                issue_cnt_q <= '0;
                pop_cnt_q   <= '0;
            end else begin
                if (rd_en)
                    issue_cnt_q <= issue_cnt_q + LEN_WIDTH'(1);
                if (pop)
                    pop_cnt_q <= pop_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

`ifdef DRAM_RD_FETCH_STRIDE_EN
    logic [ADDR_WIDTH-1:0] row_q;
    logic [LEN_WIDTH-1:0]  col_q;
    logic [LEN_WIDTH-1:0]  cols_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            row_q  <= '0;
            col_q  <= '0;
            cols_q <= '0;
        end else if (accept) begin
            row_q  <= req_base;
            col_q  <= '0;
            cols_q <= req_cols;
        end else if (rd_en) begin
            // >= keeps a zero column count from running away.
            if (col_q + LEN_WIDTH'(1) >= cols_q) begin
                col_q <= '0;
                row_q <= row_q + ADDR_WIDTH'(ROW_STRIDE);
            end else begin
                col_q <= col_q + LEN_WIDTH'(1);
            end
        end
    end

    assign rd_addr = row_q + ADDR_WIDTH'(col_q);
`else
    logic [ADDR_WIDTH-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (srst)
            addr_q <= '0;
        else if (accept)
            addr_q <= req_base;
        else if (rd_en)
            addr_q <= addr_q + ADDR_WIDTH'(1);
    end

    assign rd_addr = addr_q;
`endif

    always_ff @(posedge clk) begin
        if (!srst)
            assert (!(push && fifo_full));
    end

    fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (push),
        .din   (dram_data),
        .pop   (pop),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_dram_rd_fetch.sv
// Directed self-checking bench for dram_rd_fetch.
// Uses a 1-cycle-latency DRAM model and logs strobes/pops per cycle.
module tb_dram_rd_fetch;

    localparam int DW = 32;
    localparam int AW = 18;
    localparam int LW = 12;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_base = '0;
    logic [LW-1:0] req_len = '0;
    logic [LW-1:0] req_cols = '0;
    logic          dram_en_rd;
    logic [AW-1:0] dram_addr_rd;
    logic          dram_valid = 1'b0;
    logic [DW-1:0] dram_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc = 0;
    int busy_cnt = 0;

    logic [AW-1:0] en_addr [$];
    int            en_cyc [$];
    logic [DW-1:0] pop_data [$];
    logic          pop_last [$];
    int            pop_cyc [$];
    int            done_cyc [$];

    always #5 clk = ~clk;

    dram_rd_fetch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
`ifdef DRAM_RD_FETCH_STRIDE_EN
        ,
        .ROW_STRIDE (32)
`endif
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_base     (req_base),
        .req_len      (req_len),
`ifdef DRAM_RD_FETCH_STRIDE_EN
        .req_cols     (req_cols),
`endif
        .dram_en_rd   (dram_en_rd),
        .dram_addr_rd (dram_addr_rd),
        .dram_valid   (dram_valid),
        .dram_data    (dram_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    // DRAM: data = 0xA5000000 | address, one cycle after the strobe.
    always @(posedge clk) begin
        dram_valid <= dram_en_rd;
        dram_data  <= dram_en_rd ? (32'hA500_0000 | 32'(dram_addr_rd)) : '0;
        cyc        <= cyc + 1;
    end

    always @(negedge clk) begin
        if (dram_en_rd) begin
            en_addr.push_back(dram_addr_rd);
            en_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            pop_data.push_back(out_data);
            pop_last.push_back(out_last);
            pop_cyc.push_back(cyc);
        end
        if (done)
            done_cyc.push_back(cyc);
        if (busy)
            busy_cnt++;
    end

    task automatic clear_logs();
        en_addr.delete();
        en_cyc.delete();
        pop_data.delete();
        pop_last.delete();
        pop_cyc.delete();
        done_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic send_req(input logic [AW-1:0] b, input logic [LW-1:0] l,
                            input logic [LW-1:0] c);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_base  = b;
        req_len   = l;
        req_cols  = c;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        srst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({dram_en_rd, out_valid, out_last, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {dram_en_rd, out_valid, out_last, busy, done});
        end
        n_checks++;
        if (dram_addr_rd !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data addr %h data %h want 0",
                     dram_addr_rd, out_data);
        end
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 0", req_ready);
        end
        srst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got %b want 1", req_ready);
        end
    endtask

    task automatic test_linear();
        bit to;
        logic [AW-1:0] a;
        clear_logs();
        out_ready = 1'b1;
        send_req(18'h00100, 12'd6, 12'd0);
        wait_done(to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL linear_timeout no done pulse");
        end
        n_checks++;
        if (en_addr.size() != 6 || pop_data.size() != 6) begin
            n_fail++;
            $display("FAIL linear_count reads %0d pops %0d want 6 6",
                     en_addr.size(), pop_data.size());
        end
        for (int i = 0; i < 6 && i < en_addr.size(); i++) begin
            a = 18'h00100 + AW'(i);
            n_checks++;
            if (en_addr[i] !== a || en_cyc[i] != acc + i) begin
                n_fail++;
                $display("FAIL linear_rd%0d addr %h cyc %0d want %h %0d",
                         i, en_addr[i], en_cyc[i] - acc, a, i);
            end
        end
        for (int i = 0; i < 6 && i < pop_data.size(); i++) begin
            a = 18'h00100 + AW'(i);
            n_checks++;
            if (pop_data[i] !== (32'hA500_0000 | 32'(a)) ||
                pop_last[i] !== (i == 5) || pop_cyc[i] != acc + 2 + i) begin
                n_fail++;
                $display("FAIL linear_word%0d data %h last %b cyc %0d want %h %b %0d",
                         i, pop_data[i], pop_last[i], pop_cyc[i] - acc,
                         32'hA500_0000 | 32'(a), (i == 5), i + 2);
            end
        end
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != acc + 8) begin
            n_fail++;
            $display("FAIL linear_done pulses %0d want 1 at +8",
                     done_cyc.size());
        end
        n_checks++;
        if (busy_cnt != 8) begin
            n_fail++;
            $display("FAIL linear_busy cycles %0d want 8", busy_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [AW-1:0] a;
        clear_logs();
        out_ready = 1'b0;
        send_req(18'h00200, 12'd10, 12'd0);
        repeat (20) @(negedge clk);
        n_checks++;
        if (en_addr.size() != FD || pop_data.size() != 0 ||
            out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall reads %0d pops %0d valid %b want %0d 0 1",
                     en_addr.size(), pop_data.size(), out_valid, FD);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(to);
        n_checks++;
        if (to || en_addr.size() != 10 || pop_data.size() != 10) begin
            n_fail++;
            $display("FAIL bp_total to %b reads %0d pops %0d want 0 10 10",
                     to, en_addr.size(), pop_data.size());
        end
        for (int i = 0; i < 10 && i < pop_data.size(); i++) begin
            a = 18'h00200 + AW'(i);
            n_checks++;
            if (pop_data[i] !== (32'hA500_0000 | 32'(a)) ||
                pop_last[i] !== (i == 9)) begin
                n_fail++;
                $display("FAIL bp_word%0d data %h last %b want %h %b",
                         i, pop_data[i], pop_last[i],
                         32'hA500_0000 | 32'(a), (i == 9));
            end
        end
    endtask

    task automatic test_wrap();
        bit to;
        logic [AW-1:0] exp_a [4];
        exp_a = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        clear_logs();
        out_ready = 1'b1;
        send_req(18'h3FFFE, 12'd4, 12'd0);
        wait_done(to);
        n_checks++;
        if (to || en_addr.size() != 4 || pop_data.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_count to %b reads %0d pops %0d want 0 4 4",
                     to, en_addr.size(), pop_data.size());
        end
        for (int i = 0; i < 4 && i < en_addr.size() && i < pop_data.size(); i++) begin
            n_checks++;
            if (en_addr[i] !== exp_a[i] ||
                pop_data[i] !== (32'hA500_0000 | 32'(exp_a[i]))) begin
                n_fail++;
                $display("FAIL wrap_rd%0d addr %h data %h want %h",
                         i, en_addr[i], pop_data[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        out_ready = 1'b1;
        send_req(18'h00055, 12'd0, 12'd0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done done %b busy %b want 1 0", done, busy);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (en_addr.size() != 0 || done_cyc.size() != 1 ||
            busy_cnt != 0 || pop_data.size() != 0) begin
            n_fail++;
            $display("FAIL zero_quiet reads %0d dones %0d busy %0d pops %0d want 0 1 0 0",
                     en_addr.size(), done_cyc.size(), busy_cnt, pop_data.size());
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [AW-1:0] a;
        clear_logs();
        out_ready = 1'b1;
        send_req(18'h00300, 12'd8, 12'd0);
        repeat (4) @(posedge clk);
        #1;
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        n_checks++;
        if ({dram_en_rd, out_valid, out_last, busy, done} !== 5'b0 ||
            dram_addr_rd !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL midrst_out ctrl %b addr %h data %h want 0",
                     {dram_en_rd, out_valid, out_last, busy, done},
                     dram_addr_rd, out_data);
        end
        n_checks++;
        if (pop_data.size() != 3 ||
            pop_data[2] !== (32'hA500_0000 | 32'h00302)) begin
            n_fail++;
            $display("FAIL midrst_pre pops %0d want 3", pop_data.size());
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_stale valid %b busy %b want 0 0",
                     out_valid, busy);
        end
        clear_logs();
        send_req(18'h00040, 12'd3, 12'd0);
        wait_done(to);
        n_checks++;
        if (to || pop_data.size() != 3 || en_addr.size() != 3) begin
            n_fail++;
            $display("FAIL midrst_new to %b pops %0d reads %0d want 0 3 3",
                     to, pop_data.size(), en_addr.size());
        end
        for (int i = 0; i < 3 && i < pop_data.size(); i++) begin
            a = 18'h00040 + AW'(i);
            n_checks++;
            if (pop_data[i] !== (32'hA500_0000 | 32'(a)) ||
                pop_last[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL midrst_word%0d data %h last %b want %h %b",
                         i, pop_data[i], pop_last[i],
                         32'hA500_0000 | 32'(a), (i == 2));
            end
        end
    endtask

`ifdef DRAM_RD_FETCH_STRIDE_EN
    task automatic test_stride();
        bit to;
        logic [AW-1:0] exp_a [6];
        exp_a = '{18'd0, 18'd1, 18'd2, 18'd32, 18'd33, 18'd34};
        clear_logs();
        out_ready = 1'b1;
        send_req(18'd0, 12'd6, 12'd3);
        wait_done(to);
        n_checks++;
        if (to || en_addr.size() != 6) begin
            n_fail++;
            $display("FAIL stride_count to %b reads %0d want 0 6",
                     to, en_addr.size());
        end
        for (int i = 0; i < 6 && i < en_addr.size(); i++) begin
            n_checks++;
            if (en_addr[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL stride_rd%0d addr %h want %h",
                         i, en_addr[i], exp_a[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_linear();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_reset_mid();
`ifdef DRAM_RD_FETCH_STRIDE_EN
        test_stride();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
